hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

- Pipeline hazard controller for the 5-stage MIPS core, sitting beside the ID stage.
- Decides stalls and flushes for three cases:
  - load-use hazards;
  - branches resolved in ID whose operands are not yet forwardable;
  - taken branches.
- Schedules the shared multi-cycle mult/div unit with a busy counter, and holds later HI/LO consumers until the result is ready.
- Complements the EX-stage forwarding logic: forwarding covers every hazard this block does not stall for.

## Interface
Parameters:
- MD_LAT, 32, mult/div latency in cycles from MdStart to result ready (legal range 2..255).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- ID_Rs, ID_Rt  input  5 each  source registers of the instruction in ID.
- ID_UseRt  input  1  instruction in ID reads Rt.
- ID_Branch  input  1  ID instruction is a branch compared in ID.
- ID_MulDiv  input  1  ID instruction is mult/multu/div/divu.
- ID_MfHiLo  input  1  ID instruction is mfhi/mflo.
- BranchTaken  input  1  ID branch comparator result.
- EX_MemRead, EX_RegWrite  input  1 each  control bits of the EX-stage instruction.
- EX_WReg  input  5  destination register of the EX-stage instruction.
- MEM_MemRead  input  1  control bit of the MEM-stage instruction.
- MEM_WReg  input  5  destination register of the MEM-stage instruction.
- PCWrite  output  1  PC update enable.
- IFIDWrite  output  1  IF/ID register enable.
- IFIDFlush  output  1  zero IF/ID on next edge.
- IDEXFlush  output  1  insert bubble into ID/EX.
- MdStart  output  1  one-cycle start pulse to mult/div unit.
- MdBusy  output  1  mult/div in progress.
- MdDone  output  1  one-cycle pulse, HI/LO valid from next cycle.

## Operation
Operand match:
- match(r) = (r != 0) && (r == ID_Rs || (ID_UseRt && r == ID_Rt)).

Stall sources (all combinational):
- LoadUse = EX_MemRead && match(EX_WReg).
- BrHaz = ID_Branch && ((EX_RegWrite && match(EX_WReg)) || (MEM_MemRead && match(MEM_WReg))).
- MdHaz = (ID_MulDiv || ID_MfHiLo) && state == BUSY.
- Stall = LoadUse || BrHaz || MdHaz.

On Stall:
- PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0.
- Stall overrides BranchTaken; the branch is re-evaluated next cycle.

Without Stall:
- PCWrite=1, IFIDWrite=1, IDEXFlush=0, IFIDFlush=BranchTaken && ID_Branch.

Mult/div state machine, states IDLE and BUSY, counter cnt of width clog2(MD_LAT):
- Issue: in IDLE with ID_MulDiv && !Stall, assert MdStart; go to BUSY, cnt <= MD_LAT-1.
- BUSY, cnt != 0: cnt <= cnt-1.
- BUSY, cnt == 0: MdDone=1 that cycle; go to IDLE.
- MdStart is never asserted in BUSY, and never while Stall is high.
- MdBusy = (state == BUSY).
- A mult/div issued while another is in flight waits for IDLE, since MdHaz stalls it.

## Timing
- Stall/flush outputs are combinational from inputs and state, with no added latency.
- State and counter update on the rising edge of clk.
- MdStart at cycle T gives MdDone at cycle T+MD_LAT. An mfhi/mflo held in ID proceeds at T+MD_LAT+1.

While rst=1:
- PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXFlush=1, MdStart=0.

After the reset edge:
- State is IDLE, cnt=0, MdBusy=0, MdDone=0.

Reset in BUSY:
- Aborts the operation; no MdDone pulse is produced.

Simultaneous events:
- LoadUse and BrHaz together give a single stall cycle per edge; the stall re-evaluates each cycle.
- MdDone in the same cycle as an mfhi in ID: the mfhi is still stalled that cycle and proceeds the next cycle.
- ID_MulDiv in the MdDone cycle: stalled that cycle, issues the next cycle.

## Configuration
HAZ_STATS_EN defined:
- Adds output StallCnt, 16 bits: increments every cycle PCWrite==0 while rst==0, saturates at 16'hFFFF, cleared by rst.
- Adds output FlushCnt, 16 bits, with the same rules, counting IFIDFlush cycles.

HAZ_STATS_EN not defined:
- Neither port nor counter exists; all other behaviour is identical.

## Test plan
- Load-use: EX_MemRead=1, EX_WReg=8, ID_Rs=8 -> PCWrite=0, IFIDWrite=0, IDEXFlush=1 for exactly that cycle. The same stimulus with EX_WReg=0 -> no stall.
- Branch hazard: ID_Branch=1, ID_Rt=9, ID_UseRt=1, MEM_MemRead=1, MEM_WReg=9, BranchTaken=1 -> stall with IFIDFlush=0. Removing the MEM match -> IFIDFlush=1, PCWrite=1.
- Mult/div with MD_LAT=4: ID_MulDiv at cycle 0 -> MdStart at 0, MdBusy at 1..4, MdDone at 4. mfhi in ID from cycle 1 is stalled through cycle 4 and proceeds at 5.
- Back-to-back ops: two mult ops in consecutive cycles -> the second stalls until IDLE, then MdStart is asserted again exactly once.
- Reset mid-operation: rst at cycle 2 of BUSY -> IDLE and MdBusy=0 after that edge, no MdDone. During rst, all four pipeline controls show the reset values.
- With HAZ_STATS_EN: 3 load-use stalls plus 1 taken branch -> StallCnt=3, FlushCnt=1. Forcing 70000 stall cycles -> StallCnt holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use/branch stalls, branch flush, mult/div scheduling.
// Optional stall/flush statistics counters are enabled by defining HAZ_STATS_EN.
module hazard_ctrl #(
  parameter int MD_LAT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_Rs,
  input  logic [4:0] ID_Rt,
  input  logic       ID_UseRt,
  input  logic       ID_Branch,
  input  logic       ID_MulDiv,
  input  logic       ID_MfHiLo,
  input  logic       BranchTaken,
  input  logic       EX_MemRead,
  input  logic       EX_RegWrite,
  input  logic [4:0] EX_WReg,
  input  logic       MEM_MemRead,
  input  logic [4:0] MEM_WReg,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       IDEXFlush,
  output logic       MdStart,
  output logic       MdBusy,
  output logic       MdDone
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
`endif
);

  localparam int CW = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t     state;
  logic [CW-1:0] cnt;

  logic ex_match, mem_match;
  logic load_use, br_haz, md_haz, stall;

  always_comb begin
    ex_match  = (EX_WReg != 5'd0) &&
                (EX_WReg == ID_Rs || (ID_UseRt && EX_WReg == ID_Rt));
    mem_match = (MEM_WReg != 5'd0) &&
                (MEM_WReg == ID_Rs || (ID_UseRt && MEM_WReg == ID_Rt));
    load_use  = EX_MemRead && ex_match;
    br_haz    = ID_Branch && ((EX_RegWrite && ex_match) || (MEM_MemRead && mem_match));
    md_haz    = (ID_MulDiv || ID_MfHiLo) && (state == BUSY);
    stall     = load_use || br_haz || md_haz;
  end

  // Reset forces both pipeline registers to flush while letting the PC advance.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    if (rst) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (stall) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      IDEXFlush = 1'b1;
    end else begin
      IFIDFlush = BranchTaken && ID_Branch;
    end
  end

  assign MdStart = !rst && (state == IDLE) && ID_MulDiv && !stall;
  assign MdDone  = !rst && (state == BUSY) && (cnt == '0);
  assign MdBusy  = (state == BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MdStart) begin
            state <= BUSY;
            cnt   <= CW'(MD_LAT - 1);
          end
        end
        BUSY: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (!PCWrite && StallCnt != '1)  StallCnt <= StallCnt + 16'd1;
      if (IFIDFlush && FlushCnt != '1) FlushCnt <= FlushCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MD_LAT=4); stats checks are active when HAZ_STATS_EN is defined.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ID_Rs, ID_Rt, EX_WReg, MEM_WReg;
  logic       ID_UseRt, ID_Branch, ID_MulDiv, ID_MfHiLo, BranchTaken;
  logic       EX_MemRead, EX_RegWrite, MEM_MemRead;
  logic       PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MdStart, MdBusy, MdDone;
`ifdef HAZ_STATS_EN
  logic [15:0] StallCnt, FlushCnt;
`endif

  hazard_ctrl #(.MD_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRt(ID_UseRt), .ID_Branch(ID_Branch),
    .ID_MulDiv(ID_MulDiv), .ID_MfHiLo(ID_MfHiLo), .BranchTaken(BranchTaken),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WReg(EX_WReg),
    .MEM_MemRead(MEM_MemRead), .MEM_WReg(MEM_WReg),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXFlush(IDEXFlush), .MdStart(MdStart), .MdBusy(MdBusy), .MdDone(MdDone)
`ifdef HAZ_STATS_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  always #5 clk = ~clk;

  // Expected vector: {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MdStart, MdBusy, MdDone}
  localparam logic [6:0] RSTV  = 7'b1111000;
  localparam logic [6:0] NORM  = 7'b1100000;
  localparam logic [6:0] STALL = 7'b0001000;
  localparam logic [6:0] FLUSH = 7'b1110000;
  localparam logic [6:0] START = 7'b1100100;
  localparam logic [6:0] BSTL  = 7'b0001010;
  localparam logic [6:0] BSTLD = 7'b0001011;
  localparam logic [6:0] BUSYN = 7'b1100010;
  localparam logic [6:0] BUSYD = 7'b1100011;

  typedef struct {
    string      name;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [6:0] got;
      e   = sb.pop_front();
      got = {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MdStart, MdBusy, MdDone};
      n_checks++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (pcw,ifidw,ifidf,idexf,mdstart,mdbusy,mddone)",
                 e.name, got, e.v);
      end
    end
  end

  task automatic clr();
    rst = 1'b0;
    ID_Rs = '0; ID_Rt = '0; ID_UseRt = 1'b0; ID_Branch = 1'b0;
    ID_MulDiv = 1'b0; ID_MfHiLo = 1'b0; BranchTaken = 1'b0;
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WReg = '0;
    MEM_MemRead = 1'b0; MEM_WReg = '0;
  endtask

  // Inputs are already applied; queue the expectation and advance one cycle.
  task automatic step(input string nm, input logic [6:0] v, input bit chk = 1'b1);
    exp_t e;
    if (chk) begin
      e.name = nm;
      e.v    = v;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_cycle();
    clr(); EX_MemRead = 1'b1; EX_WReg = 5'd8; ID_Rs = 5'd8;
  endtask

`ifdef HAZ_STATS_EN
  task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
`endif

  initial begin
    clr(); rst = 1'b1;
    step("rst_first", RSTV, 1'b0);
    step("rst_held", RSTV);
    clr(); step("after_reset", NORM);

    load_use_cycle(); step("load_use", STALL);
    clr(); step("load_use_clear", NORM);
    clr(); EX_MemRead = 1'b1; EX_WReg = 5'd0; ID_Rs = 5'd0; step("load_use_r0", NORM);
    clr(); EX_MemRead = 1'b1; EX_WReg = 5'd5; ID_Rt = 5'd5; step("rt_unused", NORM);
    ID_UseRt = 1'b1; step("rt_used", STALL);

    clr(); ID_Branch = 1'b1; ID_Rt = 5'd9; ID_UseRt = 1'b1; MEM_MemRead = 1'b1;
    MEM_WReg = 5'd9; BranchTaken = 1'b1; step("br_mem_haz", STALL);
    MEM_MemRead = 1'b0; step("br_taken", FLUSH);
    clr(); ID_Branch = 1'b1; ID_Rs = 5'd9; EX_RegWrite = 1'b1; EX_WReg = 5'd9;
    BranchTaken = 1'b1; step("br_ex_haz", STALL);
    ID_Branch = 1'b0; step("alu_fwd_only", NORM);
    clr(); ID_Branch = 1'b1; ID_Rs = 5'd3; step("br_not_taken", NORM);
    clr(); ID_Branch = 1'b1; ID_Rs = 5'd7; EX_MemRead = 1'b1; EX_RegWrite = 1'b1;
    EX_WReg = 5'd7; BranchTaken = 1'b1; step("lu_and_br", STALL);
    clr(); step("lu_and_br_clear", NORM);
    load_use_cycle(); ID_MulDiv = 1'b1; step("md_blocked_by_lu", STALL);
    clr(); step("md_no_issue", NORM);

    clr(); ID_MulDiv = 1'b1; step("md_start", START);
    clr(); ID_MfHiLo = 1'b1; step("mfhi_c1", BSTL);
    step("mfhi_c2", BSTL);
    step("mfhi_c3", BSTL);
    step("mfhi_done", BSTLD);
    step("mfhi_go", NORM);

    clr(); ID_MulDiv = 1'b1; step("md2_first", START);
    step("md2_wait1", BSTL);
    step("md2_wait2", BSTL);
    step("md2_wait3", BSTL);
    step("md2_wait_done", BSTLD);
    step("md2_second", START);
    clr(); step("md2_busy1", BUSYN);
    step("md2_busy2", BUSYN);
    step("md2_busy3", BUSYN);
    step("md2_done", BUSYD);
    step("md2_idle", NORM);

    clr(); ID_MulDiv = 1'b1; step("abort_start", START);
    clr(); step("abort_busy1", BUSYN);
    rst = 1'b1; step("abort_rst", 7'b1111010);
    clr(); step("abort_idle1", NORM);
    step("abort_idle2", NORM);
    step("abort_idle3", NORM);
    step("abort_idle4", NORM);

`ifdef HAZ_STATS_EN
    clr(); rst = 1'b1; step("stats_rst", RSTV);
    load_use_cycle(); step("stats_lu1", STALL);
    clr(); step("stats_gap1", NORM);
    load_use_cycle(); step("stats_lu2", STALL);
    clr(); step("stats_gap2", NORM);
    load_use_cycle(); step("stats_lu3", STALL);
    clr(); ID_Branch = 1'b1; BranchTaken = 1'b1; step("stats_br", FLUSH);
    clr();
    chk16("stall_cnt", StallCnt, 16'd3);
    chk16("flush_cnt", FlushCnt, 16'd1);
    load_use_cycle();
    for (int i = 0; i < 70000; i++) step("stats_sat", STALL, 1'b0);
    chk16("stall_cnt_sat", StallCnt, 16'hFFFF);
    chk16("flush_cnt_hold", FlushCnt, 16'd1);
    clr();
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
